i2s_rx_deser: RTL and testbench
===============================

Name: i2s_rx_deser

Overview:
- I2S serial-audio receiver; the upstream stage of the audio filter chain (highpass and siblings).
- Oversamples the external SCK/WS/SD pins on the system clock and deserialises 16-bit MSB-first words.
- Emits one parallel two's-complement sample per channel with a single-cycle strobe that drives the filter's sample input and enable.

Parameters:
- DATA_W, 16, sample width in bits; equals the filter input width.
- SYNC_STAGES, 2, flip-flop stages in each pin synchroniser (minimum 2).

Ports:
- clk  in  1  system clock; must run at least 8x the SCK frequency.
- rst  in  1  synchronous, active-high reset.
- sck  in  1  I2S bit clock, asynchronous to clk.
- ws  in  1  I2S word select; 0 = left, 1 = right; asynchronous.
- sd  in  1  I2S serial data; asynchronous.
- sample  out  DATA_W  last completed word, two's complement.
- sample_valid  out  1  one-clk strobe; sample and channel are valid this cycle.
- channel  out  1  channel of sample (0 left, 1 right).
- frame_err  out  1  one-clk strobe coincident with sample_valid when the word was short (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - sample = 0, sample_valid = 0, channel = 0, frame_err = 0.
  - Shift register = 0, bit counter = 0.
  - FSM = ALIGN; synchroniser flops = 0.
- Pin handling:
  - sck, ws and sd each pass through SYNC_STAGES flops.
  - An SCK rising edge is detected as synced sck = 1 while the previous synced sck = 0.
  - All sampling below happens only on a detected SCK rising edge ("edge").
  - On each edge, ws_s and sd_s are captured, and ws_prev holds ws_s from the previous edge.
- FSM:
  - ALIGN: discard data. On the first edge with ws_s != ws_prev, clear the shift register and bit counter, then go to RUN. The partial first frame is never emitted.
  - RUN, edge with ws_s == ws_prev: if bitcnt < DATA_W, shift sd_s into the LSB and increment bitcnt (saturating at DATA_W). Bits beyond DATA_W are ignored, so wider slots such as 24 or 32 bits are truncated to the top 16 bits.
  - RUN, edge with ws_s != ws_prev: this bit is the LSB slot of the old word.
    - Shift it in if bitcnt < DATA_W.
    - Left-justify the word: a short word is padded with zero LSBs.
    - On the next clk, drive sample = word, channel = ws_prev and pulse sample_valid.
    - Clear the shift register and set bitcnt = 0 for the new word, which begins at the next edge.
- Latency: sample_valid rises exactly SYNC_STAGES+2 clk cycles after the pin-level SCK rise that carried the WS change.
- sample and channel hold their value until the next sample_valid; sample_valid is high for exactly 1 cycle.
- Boundary conditions:
  - WS toggles on consecutive edges (bitcnt = 0 at the change): emit sample with only the MSB possibly set, and flag frame_err if the feature is enabled.
  - SCK stops: no output and no timeout; state is held.
  - rst asserted mid-word: all state cleared, return to ALIGN, the in-progress word is lost, and no strobe is issued in the reset cycle.
  - rst and a WS-change edge in the same cycle: reset wins.

Optional Feature:
- Macro: I2S_RX_FRAME_CHECK_EN.
- Defined:
  - frame_err pulses with sample_valid whenever the emitted word received fewer than DATA_W bits.
  - A sticky internal short-frame counter (8-bit, saturating) is maintained and cleared by rst.
- Undefined: frame_err is tied to 0 and no counter logic is generated; the sample path is identical in both builds.

Decomposition:
- Package audio_pkg:
  - SAMPLE_W = 16.
  - typedef sample_t = logic signed [SAMPLE_W-1:0].
  - Channel constants CH_LEFT = 0, CH_RIGHT = 1.
  - FSM state encoding ALIGN/RUN.
- Sub-module sync_edge_det (SYNC_STAGES-deep synchroniser with optional rising-edge output), instantiated for sck (edge used), ws and sd (level only).

Test Plan:
- Reset then left word 16'hA5C3 followed by right word 16'h1234, standard I2S timing, clk = 16x SCK:
  - The partial first frame after reset is not emitted.
  - Then sample = 16'hA5C3 with channel = 0, then 16'h1234 with channel = 1.
  - Each sample_valid is 1 cycle wide, SYNC_STAGES+2 clks after the WS-change SCK edge.
- 32-bit slots carrying 16'h8001 followed by 16 bits of 1s: sample = 16'h8001; trailing bits ignored.
- Short 12-bit word 12'hABC: sample = 16'hABC0; frame_err = 1 with the macro defined, 0 without.
- rst pulsed after 7 bits of a word: no sample_valid for that word; outputs all 0; FSM re-aligns; the next complete frame after a WS edge is emitted correctly.
- Negative full scale 16'h8000 then 16'h7FFF alternating L/R for 4 frames: exact values and alternating channel, with no missed or duplicate strobes.
- SCK held static for 1000 clks mid-word, then resumed: no spurious sample_valid; the word completes correctly afterward.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type, channel codes and I2S receiver FSM encoding.
package audio_pkg;
    localparam int SAMPLE_W = 16;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;
    localparam logic [0:0] ALIGN = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: STAGES-deep pin synchroniser.
// When EDGE is set, o is a one-clk pulse on each rising edge; otherwise o is the synced level.
module sync_edge_det #(
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic o
);
    logic [STAGES-1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], d};
    end
    if (EDGE) begin : g_edge
        logic prev_q;
        always_ff @(posedge clk) prev_q <= rst ? 1'b0 : sync_q[STAGES-1];
        assign o = sync_q[STAGES-1] & ~prev_q;
    end else begin : g_level
        assign o = sync_q[STAGES-1];
    end
endmodule

// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: I2S receiver; oversamples SCK/WS/SD and emits left-justified MSB-first words.
// Define I2S_RX_FRAME_CHECK_EN to flag short words on frame_err and count them.
module i2s_rx_deser
    import audio_pkg::*;
#(
    parameter int DATA_W      = SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ws,
    input  logic              sd,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              channel,
    output logic              frame_err
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_W);
    logic sck_rise, ws_s, sd_s, ws_chg, take;
    logic [0:0] state_q, state_d;
    logic primed_q, primed_d, ws_prev_q, ws_prev_d, emit_q, emit_d, wch_q, wch_d;
    logic valid_q, channel_q;
    logic [DATA_W-1:0] shift_q, shift_d, shift_in, word_q, word_d, sample_q;
    logic [CW-1:0] cnt_q, cnt_d, cnt_in;
    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sck (.clk(clk), .rst(rst), .d(sck), .o(sck_rise));
    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_ws  (.clk(clk), .rst(rst), .d(ws),  .o(ws_s));
    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sd  (.clk(clk), .rst(rst), .d(sd),  .o(sd_s));
    // ws_prev is meaningless until one edge has been seen, so no change is declared before that
    assign ws_chg   = primed_q && (ws_s != ws_prev_q);
    assign take     = cnt_q < FULL;
    assign shift_in = take ? {shift_q[DATA_W-2:0], sd_s} : shift_q;
    assign cnt_in   = take ? cnt_q + 1'b1 : cnt_q;
    always_comb begin
        state_d   = state_q;
        primed_d  = primed_q;
        ws_prev_d = ws_prev_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        emit_d    = 1'b0;
        word_d    = word_q;
        wch_d     = wch_q;
        if (sck_rise) begin
            primed_d  = 1'b1;
            ws_prev_d = ws_s;
            if (ws_chg) begin
                state_d = RUN;
                shift_d = '0;
                cnt_d   = '0;
                emit_d  = state_q == RUN;
                word_d  = emit_d ? shift_in << (FULL - cnt_in) : word_q;
                wch_d   = emit_d ? ws_prev_q : wch_q;
            end else if (state_q == RUN) begin
                shift_d = shift_in;
                cnt_d   = cnt_in;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ALIGN;
            primed_q  <= 1'b0;
            ws_prev_q <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            emit_q    <= 1'b0;
            word_q    <= '0;
            wch_q     <= 1'b0;
            valid_q   <= 1'b0;
            sample_q  <= '0;
            channel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            primed_q  <= primed_d;
            ws_prev_q <= ws_prev_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            emit_q    <= emit_d;
            word_q    <= word_d;
            wch_q     <= wch_d;
            valid_q   <= emit_q;
            if (emit_q) begin
                sample_q  <= word_q;
                channel_q <= wch_q;
            end
        end
    end
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign channel      = channel_q;
`ifdef I2S_RX_FRAME_CHECK_EN
    logic short_q, ferr_q;
    logic [7:0] err_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            short_q   <= 1'b0;
            ferr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            short_q <= emit_d && (cnt_in != FULL);
            ferr_q  <= short_q;
            if (short_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
    assign frame_err = ferr_q;
`else
    assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: drives I2S words at 16 clk per SCK and checks emitted samples against a word-level model.
module tb_i2s_rx_deser;
    import audio_pkg::*;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif
    typedef struct {logic ch; int n; logic [31:0] val; sample_t exp_s; logic exp_short;} vec_t;
    typedef struct {logic ws; logic sd;} edge_t;
    typedef struct {logic [15:0] s; logic ch; logic fe;} out_t;
    logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ws = 1'b0, sd = 1'b0;
    logic [15:0] sample;
    logic sample_valid, channel, frame_err;
    int cyc = 0, checks = 0, passes = 0, chg_cyc = 0;
    logic last_ws = 1'b0, prev_valid = 1'b0, ch;
    edge_t edges_q[$];
    out_t exp_q[$], got_q[$];
    vec_t tbl[16];
    i2s_rx_deser #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sd(sd),
        .sample(sample), .sample_valid(sample_valid), .channel(channel), .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endfunction
    // a word of n bits keeps its top 16 bits, or is padded with zero LSBs when shorter
    function automatic logic [15:0] justify(int n, logic [31:0] v);
        logic [63:0] m;
        m = {32'b0, v} & ((64'd1 << n) - 64'd1);
        return n >= 16 ? 16'(m >> (n - 16)) : 16'(m << (16 - n));
    endfunction
    // I2S framing: MSB..bit1 sent with ws=ch, LSB sent on the edge where ws flips
    function void add_word(logic c, int n, logic [31:0] v, bit emit, logic [15:0] es, logic short_w);
        for (int i = n - 1; i >= 1; i--) edges_q.push_back('{ws: c, sd: v[i]});
        edges_q.push_back('{ws: ~c, sd: v[0]});
        if (emit) exp_q.push_back('{s: es, ch: c, fe: short_w & FE_EN});
    endfunction
    task automatic send_edges(input int k);
        edge_t e;
        for (int i = 0; i < k && edges_q.size() > 0; i++) begin
            e = edges_q.pop_front();
            @(posedge clk); #1; sck = 1'b0; ws = e.ws; sd = e.sd;
            repeat (8) @(posedge clk);
            #1; sck = 1'b1;
            if (e.ws !== last_ws) chg_cyc = cyc;
            last_ws = e.ws;
            repeat (7) @(posedge clk);
        end
    endtask
    task automatic compare(input string tag);
        repeat (20) @(posedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_sample%0d", tag, i), got_q[i].s, exp_q[i].s);
            check($sformatf("%s_channel%0d", tag, i), got_q[i].ch, exp_q[i].ch);
            check($sformatf("%s_frame_err%0d", tag, i), got_q[i].fe, exp_q[i].fe);
        end
        got_q.delete();
        exp_q.delete();
    endtask
    task automatic do_reset(input string tag);
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_sample"}, sample, 0);
            check({tag, "_valid"}, sample_valid, 0);
            check({tag, "_channel"}, channel, 0);
            check({tag, "_frame_err"}, frame_err, 0);
        end
        @(posedge clk); #1; rst = 1'b0;
    endtask
    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            check("valid_width", prev_valid, 0);
            check("latency", cyc - chg_cyc, 4);
            got_q.push_back('{s: sample, ch: channel, fe: frame_err});
        end
        prev_valid <= sample_valid;
    end
    initial begin
        tbl[0] = '{1'b0, 16, 32'hA5C3, 16'hA5C3, 1'b0};
        tbl[1] = '{1'b1, 16, 32'h1234, 16'h1234, 1'b0};
        tbl[2] = '{1'b0, 32, 32'h8001FFFF, 16'h8001, 1'b0};
        tbl[3] = '{1'b1, 24, 32'h7FFF00, 16'h7FFF, 1'b0};
        tbl[4] = '{1'b0, 12, 32'hABC, 16'hABC0, 1'b1};
        tbl[5] = '{1'b1, 16, 32'h5A5A, 16'h5A5A, 1'b0};
        tbl[6] = '{1'b0, 1, 32'h1, 16'h8000, 1'b1};
        tbl[7] = '{1'b1, 1, 32'h0, 16'h0000, 1'b1};
        for (int i = 8; i < 16; i++)
            tbl[i] = '{1'(i % 2), 16, (i % 2) ? 32'h7FFF : 32'h8000, (i % 2) ? 16'h7FFF : 16'h8000, 1'b0};
        do_reset("reset");
        // partial right frame first: must not be emitted
        add_word(1'b1, 5, 32'h15, 1'b0, 16'h0, 1'b0);
        foreach (tbl[i]) add_word(tbl[i].ch, tbl[i].n, tbl[i].val, 1'b1, tbl[i].exp_s, tbl[i].exp_short);
        send_edges(edges_q.size());
        compare("table");
        ch = 1'b0;
        for (int i = 0; i < 30; i++) begin
            int n;
            logic [31:0] v;
            n = $urandom_range(1, 32);
            v = $urandom;
            add_word(ch, n, v, 1'b1, justify(n, v), n < 16);
            ch = ~ch;
        end
        send_edges(edges_q.size());
        compare("rand");
        add_word(1'b0, 16, 32'h3C3C, 1'b1, 16'h3C3C, 1'b0);
        add_word(1'b1, 16, 32'h0F0F, 1'b1, 16'h0F0F, 1'b0);
        send_edges(6);
        repeat (1000) @(posedge clk);
        check("stall_quiet", got_q.size(), 0);
        send_edges(edges_q.size());
        compare("stall");
        add_word(1'b0, 16, 32'hC001, 1'b1, 16'hC001, 1'b0);
        for (int i = 0; i < 7; i++) edges_q.push_back('{ws: 1'b1, sd: 1'b1});
        send_edges(edges_q.size());
        @(posedge clk); #1; sck = 1'b0;
        compare("pre_rst");
        do_reset("mid_rst");
        add_word(1'b1, 9, 32'h1FF, 1'b0, 16'h0, 1'b0);
        add_word(1'b0, 16, 32'h2468, 1'b1, 16'h2468, 1'b0);
        add_word(1'b1, 16, 32'h1357, 1'b1, 16'h1357, 1'b0);
        send_edges(edges_q.size());
        compare("post_rst");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
